throw_ctl: RTL and testbench

- Per-player throw controller for the cat-and-dog artillery game.
- Turns mouse-button hold/release into a charged throw, then steps the projectile along a discrete parabola.
- Drives throw_flag to turn_manager directly downstream; the falling edge of throw_flag advances the turn.
- Also provides projectile position for the draw pipeline and a landing report for hit logic / UART.

---
 rtl/throw_ctl_if.sv | 24 ++
 rtl/throw_ctl.sv | 169 ++++++++++++++++
 tb/tb_throw_ctl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/throw_ctl_if.sv
// Signal bundle between throw_ctl and its neighbours: turn_manager, mouse front-end, draw and hit logic.
// No valid/ready pairs here: land_valid is a one-cycle pulse with no back-pressure, sinks must take it that cycle.
interface throw_ctl_if;
  logic [2:0]  turn;
  logic        mouse_left;
  logic        throw_flag;
  logic [5:0]  power;
  logic [11:0] proj_x;
  logic [11:0] proj_y;
  logic        proj_visible;
  logic [11:0] land_x;
  logic        land_valid;
  logic [1:0]  dbg_state;

  modport master (
    output turn, mouse_left,
    input  throw_flag, power, proj_x, proj_y, proj_visible, land_x, land_valid, dbg_state
  );

  modport slave (
    input  turn, mouse_left,
    output throw_flag, power, proj_x, proj_y, proj_visible, land_x, land_valid, dbg_state
  );
endinterface

// File: rtl/throw_ctl.sv
// Per-player throw controller: charges power while the mouse button is held, then steps the
// projectile along a discrete parabola and reports where it landed.
module throw_ctl #(
  parameter int PLAYER     = 1,
  parameter int START_X    = 100,
  parameter int START_Y    = 500,
  parameter int GROUND_Y   = 550,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 1023,
  parameter int POWER_MAX  = 63,
  parameter int CHARGE_DIV = 600000,
  parameter int STEP_DIV   = 1000000
) (
  input  logic        clk60MHz,
  input  logic        rst,
  throw_ctl_if.slave  bus
);
  localparam int CW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]     CHARGE_LAST = CW'(CHARGE_DIV - 1);
  localparam logic [SW-1:0]     STEP_LAST   = SW'(STEP_DIV - 1);
  localparam logic signed [12:0] START_X_S  = 13'(START_X);
  localparam logic signed [12:0] START_Y_S  = 13'(START_Y);
  localparam logic signed [12:0] GROUND_Y_S = 13'(GROUND_Y);
  localparam logic signed [12:0] X_MIN_S    = 13'(X_MIN);
  localparam logic signed [12:0] X_MAX_S    = 13'(X_MAX);
  localparam logic [5:0]        POWER_MAX_V = 6'(POWER_MAX);
  localparam logic              PLAYER_BIT  = (PLAYER % 2) != 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FLIGHT = 2'd2,
    LAND   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               ml_q, ml_prev_q;
  logic [CW-1:0]      cdiv_q, cdiv_d;
  logic [SW-1:0]      sdiv_q, sdiv_d;
  logic [5:0]         power_q, power_d;
  logic signed [12:0] px_q, px_d, py_q, py_d;
  logic signed [7:0]  vy_q, vy_d;
  logic [4:0]         vx_q, vx_d;
  logic [11:0]        land_x_q, land_x_d;

  logic               my_turn, rise, fall;
  logic [5:0]         launch_pwr;
  logic signed [12:0] vx_s, vy_s, x_new, y_new, land_px, land_py;
  logic signed [7:0]  vy_next;
  logic               hit_ground, off_left, off_right;
  logic               unused_turn;

  assign unused_turn = ^bus.turn[2:1];
  assign my_turn     = (bus.turn[0] == PLAYER_BIT);
  // Edges are taken between two registered copies, so a release is seen one cycle after it happens.
  assign rise        = ml_q & ~ml_prev_q;
  assign fall        = ~ml_q & ml_prev_q;
  assign launch_pwr  = (power_q == 6'd0) ? 6'd1 : power_q;

  assign vx_s      = signed'({8'd0, vx_q});
  assign vy_s      = signed'({{5{vy_q[7]}}, vy_q});
  assign x_new     = PLAYER_BIT ? (px_q + vx_s) : (px_q - vx_s);
  assign y_new     = py_q - vy_s;
  assign vy_next   = (vy_q == -8'sd128) ? vy_q : (vy_q - 8'sd1);
  assign hit_ground = (y_new >= GROUND_Y_S);
  assign off_left  = (x_new < X_MIN_S);
  assign off_right = (x_new > X_MAX_S);
  assign land_px   = off_left ? X_MIN_S : (off_right ? X_MAX_S : x_new);
  assign land_py   = hit_ground ? GROUND_Y_S : y_new;

  always_comb begin
    state_d  = state_q;
    cdiv_d   = cdiv_q;
    sdiv_d   = sdiv_q;
    power_d  = power_q;
    px_d     = px_q;
    py_d     = py_q;
    vy_d     = vy_q;
    vx_d     = vx_q;
    land_x_d = land_x_q;
    case (state_q)
      IDLE: begin
        if (rise && my_turn) begin
          state_d = CHARGE;
          power_d = 6'd0;
          cdiv_d  = '0;
        end
      end
      CHARGE: begin
        // A release wins over losing the turn in the same cycle.
        if (fall) begin
          state_d = FLIGHT;
          power_d = launch_pwr;
          px_d    = START_X_S;
          py_d    = START_Y_S;
          vy_d    = signed'({2'b00, launch_pwr});
          vx_d    = {1'b0, launch_pwr[5:2]} + 5'd1;
          sdiv_d  = '0;
        end else if (!my_turn) begin
          state_d = IDLE;
          power_d = 6'd0;
        end else if (cdiv_q == CHARGE_LAST) begin
          cdiv_d = '0;
          if (power_q < POWER_MAX_V) power_d = power_q + 6'd1;
        end else begin
          cdiv_d = cdiv_q + CW'(1);
        end
      end
      FLIGHT: begin
        if (sdiv_q == STEP_LAST) begin
          sdiv_d = '0;
          vy_d   = vy_next;
          if (hit_ground || off_left || off_right) begin
            state_d  = LAND;
            px_d     = land_px;
            py_d     = land_py;
            land_x_d = land_px[11:0];
          end else begin
            px_d = x_new;
            py_d = y_new;
          end
        end else begin
          sdiv_d = sdiv_q + SW'(1);
        end
      end
      LAND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (!rst) begin
      state_q   <= IDLE;
      ml_q      <= 1'b0;
      ml_prev_q <= 1'b0;
      cdiv_q    <= '0;
      sdiv_q    <= '0;
      power_q   <= 6'd0;
      px_q      <= START_X_S;
      py_q      <= START_Y_S;
      vy_q      <= 8'sd0;
      vx_q      <= 5'd0;
      land_x_q  <= 12'd0;
    end else begin
      state_q   <= state_d;
      ml_q      <= bus.mouse_left;
      ml_prev_q <= ml_q;
      cdiv_q    <= cdiv_d;
      sdiv_q    <= sdiv_d;
      power_q   <= power_d;
      px_q      <= px_d;
      py_q      <= py_d;
      vy_q      <= vy_d;
      vx_q      <= vx_d;
      land_x_q  <= land_x_d;
    end
  end

  // throw_flag spans FLIGHT plus the LAND cycle; its fall is the turn-advance event.
  assign bus.throw_flag   = (state_q == FLIGHT) || (state_q == LAND);
  assign bus.proj_visible = (state_q == FLIGHT) || (state_q == LAND);
  assign bus.land_valid   = (state_q == LAND);
  assign bus.power        = power_q;
  assign bus.proj_x       = px_q[11:0];
  assign bus.proj_y       = py_q[11:0];
  assign bus.land_x       = land_x_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_throw_ctl.sv
// Directed bench for throw_ctl: vector table for IDLE/CHARGE decisions plus hand-written
// sequences for charging, flight trajectories, landing clamps and mid-flight reset.
module tb_throw_ctl;
  localparam int CHARGE_DIV = 4;
  localparam int STEP_DIV   = 2;
  localparam int GROUND_Y   = 502;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHARGE = 2'd1;
  localparam logic [1:0] S_FLIGHT = 2'd2;

  logic clk60MHz = 1'b0;
  logic rst      = 1'b0;

  always #5 clk60MHz = ~clk60MHz;

  throw_ctl_if bus ();

  throw_ctl #(
    .PLAYER(1), .START_X(100), .START_Y(500), .GROUND_Y(GROUND_Y),
    .X_MIN(0), .X_MAX(1023), .POWER_MAX(63),
    .CHARGE_DIV(CHARGE_DIV), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    logic [2:0] turn;
    logic       ml;
    int         ncyc;
    logic [1:0] st;
    logic       flag;
    logic [5:0] pwr;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] exp_q[$];
  int          n_cmp    = 0;
  int          n_fail   = 0;
  int          land_cnt = 0;
  int          fall_cnt = 0;
  logic        prev_flag = 1'b0;

  // turn_manager stand-in: counts throw_flag falls outside reset, plus landing pulses.
  always @(negedge clk60MHz) begin
    if (rst === 1'b1 && prev_flag === 1'b1 && bus.throw_flag === 1'b0) fall_cnt++;
    if (rst === 1'b1 && bus.land_valid === 1'b1) land_cnt++;
    prev_flag = bus.throw_flag;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] turn, input logic ml);
    bus.turn       = turn;
    bus.mouse_left = ml;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk60MHz);
  endtask

  task automatic wait_land(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk60MHz);
      if (bus.land_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_flag(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk60MHz);
      if (bus.throw_flag === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_move(input int bound, output logic [23:0] pos, output bit ok);
    logic [23:0] start;
    start = {bus.proj_x, bus.proj_y};
    ok    = 1'b0;
    pos   = start;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk60MHz);
      if ({bus.proj_x, bus.proj_y} != start) begin
        pos = {bus.proj_x, bus.proj_y};
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_trajectory(input string name);
    logic [23:0] pos, exp;
    bit ok;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_move(10, pos, ok);
      check({name, "_moved"}, int'(ok), 1);
      check({name, "_x"}, int'(pos[23:12]), int'(exp[23:12]));
      check({name, "_y"}, int'(pos[11:0]), int'(exp[11:0]));
    end
  endtask

  initial begin
    bit          ok;
    logic [23:0] pos;

    // Turn 010 rows: not our turn. Then a charge released as the turn drops (release wins),
    // the resulting flight to IDLE, and a charge aborted by losing the turn.
    vecs.push_back('{3'b010, 1'b1, 3,  S_IDLE,   1'b0, 6'd0});
    vecs.push_back('{3'b010, 1'b0, 3,  S_IDLE,   1'b0, 6'd0});
    vecs.push_back('{3'b001, 1'b1, 1,  S_IDLE,   1'b0, 6'd0});
    vecs.push_back('{3'b001, 1'b1, 1,  S_CHARGE, 1'b0, 6'd0});
    vecs.push_back('{3'b001, 1'b1, 4,  S_CHARGE, 1'b0, 6'd1});
    vecs.push_back('{3'b001, 1'b1, 4,  S_CHARGE, 1'b0, 6'd2});
    vecs.push_back('{3'b001, 1'b0, 1,  S_CHARGE, 1'b0, 6'd2});
    vecs.push_back('{3'b010, 1'b0, 1,  S_FLIGHT, 1'b1, 6'd2});
    vecs.push_back('{3'b010, 1'b0, 20, S_IDLE,   1'b0, 6'd2});
    vecs.push_back('{3'b001, 1'b1, 1,  S_IDLE,   1'b0, 6'd2});
    vecs.push_back('{3'b001, 1'b1, 1,  S_CHARGE, 1'b0, 6'd0});
    vecs.push_back('{3'b001, 1'b1, 4,  S_CHARGE, 1'b0, 6'd1});
    vecs.push_back('{3'b010, 1'b1, 1,  S_IDLE,   1'b0, 6'd0});
    vecs.push_back('{3'b010, 1'b0, 4,  S_IDLE,   1'b0, 6'd0});
    vecs.push_back('{3'b001, 1'b0, 2,  S_IDLE,   1'b0, 6'd0});

    drive(3'b001, 1'b0);
    rst = 1'b0;
    cycles(3);
    check("rst_state", int'(bus.dbg_state), int'(S_IDLE));
    check("rst_flag", int'(bus.throw_flag), 0);
    check("rst_power", int'(bus.power), 0);
    check("rst_x", int'(bus.proj_x), 100);
    check("rst_y", int'(bus.proj_y), 500);
    check("rst_visible", int'(bus.proj_visible), 0);
    check("rst_land_x", int'(bus.land_x), 0);
    check("rst_land_valid", int'(bus.land_valid), 0);
    rst = 1'b1;
    cycles(1);

    foreach (vecs[i]) begin
      drive(vecs[i].turn, vecs[i].ml);
      cycles(vecs[i].ncyc);
      check($sformatf("vec%0d_state", i), int'(bus.dbg_state), int'(vecs[i].st));
      check($sformatf("vec%0d_flag", i), int'(bus.throw_flag), int'(vecs[i].flag));
      check($sformatf("vec%0d_power", i), int'(bus.power), int'(vecs[i].pwr));
    end

    // Hold 41 cycles: power 10, flag rises 2 cycles after release, lands at x=166.
    drive(3'b001, 1'b1);
    cycles(41);
    drive(3'b001, 1'b0);
    cycles(1);
    check("t1_power_at_release", int'(bus.power), 10);
    check("t1_flag_not_yet", int'(bus.throw_flag), 0);
    cycles(1);
    check("t1_flag_rise", int'(bus.throw_flag), 1);
    check("t1_visible", int'(bus.proj_visible), 1);
    check("t1_launch_x", int'(bus.proj_x), 100);
    check("t1_launch_y", int'(bus.proj_y), 500);
    wait_land(200, ok);
    check("t1_land_seen", int'(ok), 1);
    check("t1_land_x", int'(bus.land_x), 166);
    check("t1_land_y", int'(bus.proj_y), GROUND_Y);
    check("t1_flag_in_land", int'(bus.throw_flag), 1);
    cycles(1);
    check("t1_flag_after", int'(bus.throw_flag), 0);
    check("t1_visible_after", int'(bus.proj_visible), 0);
    check("t1_land_valid_pulse", int'(bus.land_valid), 0);
    check("t1_state_after", int'(bus.dbg_state), int'(S_IDLE));
    check("t1_power_held", int'(bus.power), 10);
    check("t1_land_x_held", int'(bus.land_x), 166);

    // Quick tap: power forced to 1, four steps to the ground.
    drive(3'b001, 1'b1);
    cycles(2);
    drive(3'b001, 1'b0);
    cycles(2);
    check("t2_state", int'(bus.dbg_state), int'(S_FLIGHT));
    check("t2_power_forced", int'(bus.power), 1);
    exp_q.push_back({12'd101, 12'd499});
    exp_q.push_back({12'd102, 12'd499});
    exp_q.push_back({12'd103, 12'd500});
    exp_q.push_back({12'd104, 12'd502});
    check_trajectory("t2_step");
    check("t2_land_valid", int'(bus.land_valid), 1);
    check("t2_land_x", int'(bus.land_x), 104);
    cycles(1);
    check("t2_flag_after", int'(bus.throw_flag), 0);
    check("t2_visible_after", int'(bus.proj_visible), 0);

    // Long hold: power saturates, vx=16, flight leaves the field on the right.
    drive(3'b001, 1'b1);
    cycles(400);
    check("t4_power_sat", int'(bus.power), 63);
    drive(3'b001, 1'b0);
    wait_flag(5, ok);
    check("t4_launched", int'(ok), 1);
    exp_q.push_back({12'd116, 12'd437});
    check_trajectory("t4_step1");
    wait_land(300, ok);
    check("t4_land_seen", int'(ok), 1);
    check("t4_land_x", int'(bus.land_x), 1023);
    check("t4_proj_x", int'(bus.proj_x), 1023);
    cycles(1);
    check("t4_flag_after", int'(bus.throw_flag), 0);

    // Reset during the third flight step.
    drive(3'b001, 1'b1);
    cycles(2);
    drive(3'b001, 1'b0);
    cycles(2);
    wait_move(10, pos, ok);
    check("t6_step1", int'(pos[23:12]), 101);
    wait_move(10, pos, ok);
    check("t6_step2", int'(pos[23:12]), 102);
    rst = 1'b0;
    cycles(1);
    check("t6_flag", int'(bus.throw_flag), 0);
    check("t6_visible", int'(bus.proj_visible), 0);
    check("t6_state", int'(bus.dbg_state), int'(S_IDLE));
    check("t6_x", int'(bus.proj_x), 100);
    check("t6_y", int'(bus.proj_y), 500);
    check("t6_power", int'(bus.power), 0);
    check("t6_land_valid", int'(bus.land_valid), 0);
    check("t6_land_x", int'(bus.land_x), 0);
    cycles(2);
    rst = 1'b1;
    cycles(10);
    check("t6_stays_idle", int'(bus.dbg_state), int'(S_IDLE));

    check("turns_advanced", fall_cnt, 4);
    check("land_pulses", land_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
